// File: rtl/accel_sched_pkg.sv
// rtl/accel_sched_pkg.sv - shared state encoding and width defaults for the key range scheduler
package accel_sched_pkg;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_END      = 2'd3
   } sched_state_t;

   localparam int KEY_W_DEF   = 32;
   localparam int CHUNK_W_DEF = 16;
   localparam int PERF_W      = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requesting, non-outstanding core at or after the pointer
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [N-1:0]  i_busy_mask,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_next_ptr,
   output logic          o_valid
);
   always_comb begin
      int idx;
      idx        = 0;
      o_gnt      = '0;
      o_next_ptr = i_ptr;
      o_valid    = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = int'(i_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!o_valid && i_req[idx] && !i_busy_mask[idx]) begin
            o_valid    = 1'b1;
            o_gnt[idx] = 1'b1;
            o_next_ptr = (idx == N-1) ? '0 : PW'(idx + 1);
         end
      end
   end
endmodule

// File: rtl/key_range_scheduler.sv
// rtl/key_range_scheduler.sv - hands out key chunks to cracker cores and latches the first match
// ACCEL_PERF_COUNT_EN: when defined, o_chunks_issued counts grants since the last start.
module key_range_scheduler
   import accel_sched_pkg::*;
#(
   parameter int N_CORES = 4,
   parameter int KEY_W   = KEY_W_DEF,
   parameter int CHUNK_W = CHUNK_W_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [KEY_W-1:0]         i_key_base,
   input  logic [KEY_W-1:0]         i_key_limit,
   input  logic [N_CORES-1:0]       i_core_req,
   input  logic [N_CORES-1:0]       i_core_done,
   input  logic [N_CORES-1:0]       i_core_found,
   input  logic [N_CORES*KEY_W-1:0] i_core_key,
   output logic [N_CORES-1:0]       o_grant,
   output logic [KEY_W-1:0]         o_chunk_first,
   output logic [KEY_W-1:0]         o_chunk_last,
   output logic                     o_stop_all,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_found,
   output logic [KEY_W-1:0]         o_found_key,
   output logic [PERF_W-1:0]        o_chunks_issued
);
   localparam int             PTR_W      = $clog2(N_CORES);
   localparam logic [KEY_W:0] ONE        = {{KEY_W{1'b0}}, 1'b1};
   localparam logic [KEY_W:0] CHUNK_SZ   = ONE << CHUNK_W;
   localparam logic [KEY_W:0] CHUNK_SPAN = CHUNK_SZ - ONE;

   sched_state_t        r_state, w_state_nxt;
   logic [KEY_W:0]      r_next_key;
   logic [KEY_W-1:0]    r_key_limit;
   logic [N_CORES-1:0]  r_outstanding;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic [N_CORES-1:0]  r_grant;
   logic [KEY_W-1:0]    r_chunk_first, r_chunk_last, r_found_key;
   logic                r_found;

   logic [N_CORES-1:0]  w_arb_gnt;
   logic [PTR_W-1:0]    w_arb_next_ptr;
   logic                w_arb_valid;
   logic                w_active, w_start, w_any_found, w_abort, w_exhausted, w_do_grant;
   logic [KEY_W:0]      w_chunk_end;
   logic [KEY_W-1:0]    w_chunk_last, w_found_key;

   rr_arbiter #(.N(N_CORES), .PW(PTR_W)) u_arb (
      .i_req       (i_core_req),
      .i_busy_mask (r_outstanding),
      .i_ptr       (r_rr_ptr),
      .o_gnt       (w_arb_gnt),
      .o_next_ptr  (w_arb_next_ptr),
      .o_valid     (w_arb_valid)
   );

   assign w_active    = (r_state == ST_DISPATCH) || (r_state == ST_DRAIN);
   assign w_start     = i_start && !w_active;
   assign w_any_found = w_active && (|i_core_found);
   assign w_abort     = w_active && i_abort;
   // next_key is one bit wider so a carry past the top of the key space also reads as exhausted
   assign w_exhausted = r_next_key > {1'b0, r_key_limit};
   assign w_do_grant  = (r_state == ST_DISPATCH) && !w_exhausted && !(|i_core_found)
                        && !i_abort && w_arb_valid;
   assign w_chunk_end  = r_next_key + CHUNK_SPAN;
   assign w_chunk_last = (w_chunk_end > {1'b0, r_key_limit}) ? r_key_limit : w_chunk_end[KEY_W-1:0];

   always_comb begin
      w_found_key = '0;
      for (int i = N_CORES-1; i >= 0; i--)
         if (i_core_found[i]) w_found_key = i_core_key[i*KEY_W +: KEY_W];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_next_key    <= '0;
         r_key_limit   <= '0;
         r_outstanding <= '0;
         r_rr_ptr      <= '0;
         r_grant       <= '0;
         r_chunk_first <= '0;
         r_chunk_last  <= '0;
         r_found       <= 1'b0;
         r_found_key   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_do_grant ? w_arb_gnt : '0;
         if (w_start) begin
            r_next_key    <= {1'b0, i_key_base};
            r_key_limit   <= i_key_limit;
            r_outstanding <= '0;
            r_found       <= 1'b0;
            r_found_key   <= '0;
         end else if (w_any_found) begin
            r_found       <= 1'b1;
            r_found_key   <= w_found_key;
            r_outstanding <= '0;
         end else if (w_abort) begin
            r_outstanding <= '0;
         end else if (w_active) begin
            r_outstanding <= (r_outstanding & ~i_core_done) | (w_do_grant ? w_arb_gnt : '0);
         end
         if (w_do_grant) begin
            r_next_key    <= r_next_key + CHUNK_SZ;
            r_rr_ptr      <= w_arb_next_ptr;
            r_chunk_first <= r_next_key[KEY_W-1:0];
            r_chunk_last  <= w_chunk_last;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_END: if (i_start) w_state_nxt = ST_DISPATCH;
         ST_DISPATCH: begin
            if ((|i_core_found) || i_abort) w_state_nxt = ST_END;
            else if (w_exhausted)           w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((|i_core_found) || i_abort || (r_outstanding == '0)) w_state_nxt = ST_END;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_stop_all = 1'b0;
      case (r_state)
         ST_DISPATCH, ST_DRAIN: o_busy = 1'b1;
         ST_END: begin
            o_done     = 1'b1;
            o_stop_all = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_grant       = r_grant;
   assign o_chunk_first = r_chunk_first;
   assign o_chunk_last  = r_chunk_last;
   assign o_found       = r_found;
   assign o_found_key   = r_found_key;

`ifdef ACCEL_PERF_COUNT_EN
   logic [PERF_W-1:0] r_chunks_issued;
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start)
         r_chunks_issued <= '0;
      else if (w_do_grant && (r_chunks_issued != '1))
         r_chunks_issued <= r_chunks_issued + PERF_W'(1);
   end
   assign o_chunks_issued = r_chunks_issued;
`else
   assign o_chunks_issued = '0;
`endif
endmodule

// File: tb/tb_key_range_scheduler.sv
// tb/tb_key_range_scheduler.sv - randomized bench for key_range_scheduler against a chunk-list reference model
module tb_key_range_scheduler;
   localparam int      N     = 4;
   localparam longint  CHUNK = 65536;
   localparam longint  KMAX  = 64'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, abort = 1'b0;
   logic [31:0]   key_base = '0, key_limit = '0;
   logic [N-1:0]  core_req = '0, core_done = '0, core_found = '0;
   logic [N*32-1:0] core_key = '0;
   logic [N-1:0]  o_grant;
   logic [31:0]   o_chunk_first, o_chunk_last, o_found_key;
   logic          o_stop_all, o_busy, o_done, o_found;
   logic [15:0]   o_chunks_issued;

   key_range_scheduler #(.N_CORES(N), .KEY_W(32), .CHUNK_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_key_base(key_base), .i_key_limit(key_limit),
      .i_core_req(core_req), .i_core_done(core_done), .i_core_found(core_found), .i_core_key(core_key),
      .o_grant(o_grant), .o_chunk_first(o_chunk_first), .o_chunk_last(o_chunk_last),
      .o_stop_all(o_stop_all), .o_busy(o_busy), .o_done(o_done), .o_found(o_found),
      .o_found_key(o_found_key), .o_chunks_issued(o_chunks_issued)
   );

   always #5 clk = ~clk;

   typedef struct { longint first; longint last; } chunk_t;
   chunk_t  expq[$];
   int      total = 0, bad = 0;
   int      mptr = 0;
   int      ngr_run = 0;
   logic [N-1:0] mout = '0;
   bit      c_busy[N];
   int      c_cnt[N];
   longint  c_first[N], c_last[N];
   bit      match_en = 0;
   longint  match_key = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic longint exp_count(input int n);
`ifdef ACCEL_PERF_COUNT_EN
      return longint'(n);
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (o_grant != '0) mptr = (oh_idx(o_grant) + 1) % N;
   endtask

   // One clock of the core array: checks the grant produced by the inputs just applied, then
   // lets every busy core count down and report done or found.
   task automatic step();
      int mp0, idx, e;
      logic [N-1:0] preq, pdone, pfound;
      chunk_t ch;
      mp0 = mptr; preq = core_req; pdone = core_done; pfound = core_found;
      tick();
      if (o_grant != '0) begin
         ngr_run++;
         check_val("grant_onehot", 64'($countones(o_grant)), 64'd1);
         idx = oh_idx(o_grant);
         e = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (mp0 + k) % N;
            if (e < 0 && preq[j] && !mout[j]) e = j;
         end
         check_val("grant_idx", 64'(idx), 64'(e));
         check_val("grant_after_found", 64'(pfound), 64'd0);
         check_val("busy_on_grant", 64'(o_busy), 64'd1);
         if (expq.size() == 0) check_val("extra_grant", 64'(o_grant), 64'd0);
         else begin
            ch = expq.pop_front();
            check_val("chunk_first", 64'(o_chunk_first), ch.first);
            check_val("chunk_last", 64'(o_chunk_last), ch.last);
            c_first[idx] = ch.first;
            c_last[idx]  = ch.last;
         end
         c_busy[idx] = 1;
         c_cnt[idx]  = int'($urandom_range(0, 3));
      end
      mout = (mout & ~pdone) | o_grant;
      core_done = '0; core_found = '0; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (o_stop_all) c_busy[i] = 0;
         else if (c_busy[i]) begin
            if (c_cnt[i] > 0) c_cnt[i]--;
            else begin
               c_busy[i] = 0;
               if (match_en && match_key >= c_first[i] && match_key <= c_last[i]) begin
                  core_found[i] = 1'b1;
                  core_key[i*32 +: 32] = 32'(match_key);
               end else core_done[i] = 1'b1;
            end
         end
         core_req[i] = !c_busy[i];
      end
   endtask

   task automatic run_search(input longint base, input longint limit, input bit men, input longint mk);
      expq.delete();
      for (longint k = base; k <= limit; k += CHUNK)
         expq.push_back('{first: k, last: (k + CHUNK - 1 > limit) ? limit : k + CHUNK - 1});
      for (int i = 0; i < N; i++) begin c_busy[i] = 0; c_cnt[i] = 0; end
      mout = '0; ngr_run = 0; match_en = men; match_key = mk;
      key_base = 32'(base); key_limit = 32'(limit);
      core_req = '1; core_done = '0; core_found = '0;
      start = 1'b1;
      step();
      for (int c = 0; c < 600 && !o_done; c++) step();
      check_val("run_done", 64'(o_done), 64'd1);
      check_val("run_stop_all", 64'(o_stop_all), 64'd1);
      check_val("run_busy", 64'(o_busy), 64'd0);
      check_val("run_found", 64'(o_found), 64'(men));
      check_val("run_found_key", 64'(o_found_key), men ? mk : 64'd0);
      if (!men) check_val("chunks_left", 64'(expq.size()), 64'd0);
      check_val("chunks_issued", 64'(o_chunks_issued), exp_count(ngr_run));
      match_en = 0;
   endtask

   initial begin
      int ng;
      longint b, l, mk;
      bit men;
      tick(); tick();
      check_val("rst_grant", 64'(o_grant), 64'd0);
      check_val("rst_busy", 64'(o_busy), 64'd0);
      check_val("rst_done", 64'(o_done), 64'd0);
      check_val("rst_stop_all", 64'(o_stop_all), 64'd0);
      check_val("rst_found", 64'(o_found), 64'd0);
      check_val("rst_chunks", 64'(o_chunks_issued), 64'd0);
      rst = 1'b0;
      mptr = 0;

      run_search(0, 64'h3FFFF, 0, 0);
      run_search(0, 64'h18000, 0, 0);
      run_search(64'hFFFF0000, KMAX, 0, 0);
      run_search(64'h20000, 64'h4FFFF, 1, 64'h31234);

      // two cores report a match together while an idle core is requesting
      key_base = 32'h0; key_limit = 32'hFFFFF; core_req = '1; start = 1'b1;
      tick(); start = 1'b0;
      ng = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (o_grant != '0) ng++;
         core_req = core_req & ~o_grant;
      end
      check_val("t3_grants", 64'(ng), 64'd4);
      core_done = 4'b0001; core_req = 4'b0001;
      tick();
      core_done = '0; core_found = 4'b0110;
      core_key[1*32 +: 32] = 32'h1234; core_key[2*32 +: 32] = 32'h5678;
      tick();
      core_found = '0;
      check_val("t3_no_grant", 64'(o_grant), 64'd0);
      check_val("t3_found", 64'(o_found), 64'd1);
      check_val("t3_found_key", 64'(o_found_key), 64'h1234);
      check_val("t3_stop_all", 64'(o_stop_all), 64'd1);

      // abort mid-dispatch, then an empty range
      key_base = 32'h0; key_limit = 32'hFFFFF; core_req = '1; start = 1'b1;
      tick(); start = 1'b0;
      for (int c = 0; c < 3; c++) begin tick(); core_req = core_req & ~o_grant; end
      abort = 1'b1;
      tick(); abort = 1'b0;
      check_val("t5_abort_stop", 64'(o_stop_all), 64'd1);
      check_val("t5_abort_done", 64'(o_done), 64'd1);
      check_val("t5_abort_found", 64'(o_found), 64'd0);
      core_req = '1;
      for (int c = 0; c < 5; c++) begin tick(); check_val("t5_idle_grant", 64'(o_grant), 64'd0); end
      key_base = 32'h50000; key_limit = 32'h40000; start = 1'b1;
      tick(); start = 1'b0;
      ng = 0;
      for (int c = 0; c < 20 && !o_done; c++) begin tick(); if (o_grant != '0) ng++; end
      check_val("t5_empty_grants", 64'(ng), 64'd0);
      check_val("t5_empty_done", 64'(o_done), 64'd1);
      check_val("t5_empty_found", 64'(o_found), 64'd0);

      for (int r = 0; r < 12; r++) begin
         b = longint'($urandom);
         if (r % 4 == 3) b = KMAX - longint'($urandom_range(0, 200000));
         l = b + longint'($urandom_range(0, 5 * 65536));
         if (l > KMAX) l = KMAX;
         if (r % 5 == 4 && b > 0) l = b - 1 - longint'($urandom_range(0, 1000));
         if (l < 0) l = 0;
         men = (r % 3 == 1) && (l >= b);
         mk  = men ? b + longint'($urandom_range(0, 32'(l - b))) : 0;
         run_search(b, l, men, mk);
      end

      // reset while draining
      key_base = 32'h0; key_limit = 32'h2FFFF; core_req = '1; core_done = '0; core_found = '0;
      start = 1'b1;
      tick(); start = 1'b0;
      ng = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (o_grant != '0) ng++;
         core_req = core_req & ~o_grant;
      end
      check_val("t6_grants", 64'(ng), 64'd3);
      check_val("t6_busy", 64'(o_busy), 64'd1);
      check_val("t6_chunks_issued", 64'(o_chunks_issued), exp_count(3));
      rst = 1'b1;
      tick();
      rst = 1'b0; mptr = 0;
      check_val("t6_grant", 64'(o_grant), 64'd0);
      check_val("t6_busy_rst", 64'(o_busy), 64'd0);
      check_val("t6_done", 64'(o_done), 64'd0);
      check_val("t6_stop_all", 64'(o_stop_all), 64'd0);
      check_val("t6_found", 64'(o_found), 64'd0);
      check_val("t6_chunk_first", 64'(o_chunk_first), 64'd0);
      check_val("t6_chunk_last", 64'(o_chunk_last), 64'd0);
      check_val("t6_chunks_rst", 64'(o_chunks_issued), 64'd0);

      run_search(64'h1000, 64'h3A000, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
